commit_store_buffer: RTL and testbench



---
 rtl/mips_core_pkg.sv | 17 +
 rtl/sb_fwd_match.sv | 43 ++++
 rtl/commit_store_buffer.sv | 94 +++++++++
 tb/tb_commit_store_buffer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared core constants and the store-buffer entry layout.
// The store buffer and its forwarding matcher both import from here.
package mips_core_pkg;

    localparam int SB_DEPTH      = 4;
    localparam int SB_DEPTH_BITS = $clog2(SB_DEPTH);
    localparam int ADDR_WIDTH    = 26;
    localparam int DATA_WIDTH    = 32;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [3:0]            be;
    } sb_entry;

endpackage

// File: rtl/sb_fwd_match.sv
// Combinational youngest-first address matcher over the store-buffer entries.
// A youngest full-word match forwards its data; a youngest partial match reports partial.
module sb_fwd_match
    import mips_core_pkg::*;
#(
    parameter  int DEPTH    = SB_DEPTH,
    localparam int PTR_BITS = $clog2(DEPTH)
) (
    input  sb_entry               entries [DEPTH],
    input  logic [PTR_BITS:0]     wr_ptr,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    output logic                  hit,
    output logic                  partial,
    output logic [DATA_WIDTH-1:0] data
);

    // Age 0 is the slot just behind wr_ptr, i.e. the youngest store.
    logic [PTR_BITS-1:0] age_idx [DEPTH];
    logic [DEPTH-1:0]    match;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            assign age_idx[gi] = wr_ptr[PTR_BITS-1:0] - PTR_BITS'(gi + 1);
            assign match[gi]   = entries[age_idx[gi]].valid &&
                                 (entries[age_idx[gi]].addr == ld_addr);
        end
    endgenerate

    // Scan oldest to youngest so the youngest match has the final say.
    always_comb begin
        hit     = 1'b0;
        partial = 1'b0;
        data    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = (entries[age_idx[i]].be == 4'b1111);
                partial = (entries[age_idx[i]].be != 4'b1111);
                data    = (entries[age_idx[i]].be == 4'b1111) ? entries[age_idx[i]].data : '0;
            end
        end
    end

endmodule

// File: rtl/commit_store_buffer.sv
// Circular FIFO of committed stores draining in order to the D-cache,
// with store-to-load forwarding and a partial-overlap stall for the load path.
module commit_store_buffer #(
    parameter int SB_DEPTH   = mips_core_pkg::SB_DEPTH,
    parameter int ADDR_WIDTH = mips_core_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = mips_core_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  commit_wr_en,
    input  logic [ADDR_WIDTH-1:0] commit_wr_addr,
    input  logic [DATA_WIDTH-1:0] commit_wr_data,
    input  logic [3:0]            commit_wr_be,
    output logic                  sb_full,
    output logic                  sb_empty,
    output logic                  dc_req_valid,
    output logic [ADDR_WIDTH-1:0] dc_req_addr,
    output logic [DATA_WIDTH-1:0] dc_req_data,
    output logic [3:0]            dc_req_be,
    input  logic                  dc_req_ready,
    input  logic                  ld_chk_valid,
    input  logic [ADDR_WIDTH-1:0] ld_chk_addr,
    output logic                  ld_fwd_hit,
    output logic [DATA_WIDTH-1:0] ld_fwd_data,
    output logic                  ld_fwd_stall
);

    import mips_core_pkg::sb_entry;

    localparam int PTR_BITS = $clog2(SB_DEPTH);

    sb_entry             entries_reg [SB_DEPTH];
    logic [PTR_BITS:0]   wr_ptr_reg;
    logic [PTR_BITS:0]   rd_ptr_reg;
    logic [PTR_BITS-1:0] wr_idx;
    logic [PTR_BITS-1:0] rd_idx;
    logic                do_enq;
    logic                do_deq;
    logic                match_hit;
    logic                match_partial;
    logic [DATA_WIDTH-1:0] match_data;

    assign wr_idx   = wr_ptr_reg[PTR_BITS-1:0];
    assign rd_idx   = rd_ptr_reg[PTR_BITS-1:0];
    assign sb_empty = (wr_ptr_reg == rd_ptr_reg);
    assign sb_full  = (wr_idx == rd_idx) && (wr_ptr_reg[PTR_BITS] != rd_ptr_reg[PTR_BITS]);

    // Full is judged on registered pointers, so a drain cannot make room in the same cycle.
    assign do_enq = commit_wr_en && !sb_full;
    assign do_deq = !sb_empty && dc_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                entries_reg[i] <= '0;
            end
        end else begin
            if (do_enq) begin
                entries_reg[wr_idx].valid <= 1'b1;
                entries_reg[wr_idx].addr  <= commit_wr_addr;
                entries_reg[wr_idx].data  <= commit_wr_data;
                entries_reg[wr_idx].be    <= commit_wr_be;
                wr_ptr_reg                <= wr_ptr_reg + 1'b1;
            end
            if (do_deq) begin
                entries_reg[rd_idx].valid <= 1'b0;
                rd_ptr_reg                <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign dc_req_valid = !sb_empty;
    assign dc_req_addr  = sb_empty ? '0 : entries_reg[rd_idx].addr;
    assign dc_req_data  = sb_empty ? '0 : entries_reg[rd_idx].data;
    assign dc_req_be    = sb_empty ? '0 : entries_reg[rd_idx].be;

    sb_fwd_match #(
        .DEPTH(SB_DEPTH)
    ) u_fwd_match (
        .entries (entries_reg),
        .wr_ptr  (wr_ptr_reg),
        .ld_addr (ld_chk_addr),
        .hit     (match_hit),
        .partial (match_partial),
        .data    (match_data)
    );

    assign ld_fwd_hit   = ld_chk_valid && match_hit;
    assign ld_fwd_stall = ld_chk_valid && match_partial;
    assign ld_fwd_data  = ld_chk_valid ? match_data : '0;

endmodule

// File: tb/tb_commit_store_buffer.sv
// Directed bench for commit_store_buffer: enqueue/drain ordering, full/empty flags,
// pointer wrap, forwarding priority, partial stall and asynchronous reset.
module tb_commit_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_wr_en;
    logic [25:0] commit_wr_addr;
    logic [31:0] commit_wr_data;
    logic [3:0]  commit_wr_be;
    logic        sb_full;
    logic        sb_empty;
    logic        dc_req_valid;
    logic [25:0] dc_req_addr;
    logic [31:0] dc_req_data;
    logic [3:0]  dc_req_be;
    logic        dc_req_ready;
    logic        ld_chk_valid;
    logic [25:0] ld_chk_addr;
    logic        ld_fwd_hit;
    logic [31:0] ld_fwd_data;
    logic        ld_fwd_stall;

    int checks = 0;
    int errors = 0;
    logic allow_overcommit = 1'b0;

    always #5 clk = ~clk;

    commit_store_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .commit_wr_en   (commit_wr_en),
        .commit_wr_addr (commit_wr_addr),
        .commit_wr_data (commit_wr_data),
        .commit_wr_be   (commit_wr_be),
        .sb_full        (sb_full),
        .sb_empty       (sb_empty),
        .dc_req_valid   (dc_req_valid),
        .dc_req_addr    (dc_req_addr),
        .dc_req_data    (dc_req_data),
        .dc_req_be      (dc_req_be),
        .dc_req_ready   (dc_req_ready),
        .ld_chk_valid   (ld_chk_valid),
        .ld_chk_addr    (ld_chk_addr),
        .ld_fwd_hit     (ld_fwd_hit),
        .ld_fwd_data    (ld_fwd_data),
        .ld_fwd_stall   (ld_fwd_stall)
    );

    // The ROB must never commit into a full buffer, except where a test does it on purpose.
    always @(posedge clk) begin
        if (!rst && !allow_overcommit) begin
            assert (!(commit_wr_en && sb_full))
            else $error("commit while sb_full");
        end
    end

    // Stimulus helpers: called at a negedge, return at the next negedge.
    task automatic do_commit(input logic [25:0] a, input logic [31:0] d, input logic [3:0] be);
        commit_wr_en   = 1'b1;
        commit_wr_addr = a;
        commit_wr_data = d;
        commit_wr_be   = be;
        @(negedge clk);
        commit_wr_en = 1'b0;
        $display("commit addr=%h data=%h be=%b", a, d, be);
    endtask

    task automatic do_drain();
        dc_req_ready = 1'b1;
        @(negedge clk);
        dc_req_ready = 1'b0;
        $display("drain one entry");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", sb_empty); end
        checks++; if (sb_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", sb_full); end
        checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dc_req_valid); end
        checks++; if (dc_req_addr !== 26'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", dc_req_addr); end
        rst = 1'b0;
        @(negedge clk);
        ld_chk_valid = 1'b1;
        ld_chk_addr  = 26'h0;
        #1;
        checks++; if ({ld_fwd_hit, ld_fwd_stall} !== 2'b00) begin errors++; $display("FAIL idle_probe got %b exp 00", {ld_fwd_hit, ld_fwd_stall}); end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL idle_empty got %b exp 1", sb_empty); end
        ld_chk_valid = 1'b0;
        $display("reset and idle done");
    endtask

    task automatic test_single();
        do_commit(26'h100, 32'hDEADBEEF, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({dc_req_valid, dc_req_addr, dc_req_data, dc_req_be} !== {1'b1, 26'h100, 32'hDEADBEEF, 4'b1111}) begin
                errors++;
                $display("FAIL hold_req cycle %0d got v=%b a=%h d=%h be=%b exp v=1 a=100 d=deadbeef be=1111",
                         i, dc_req_valid, dc_req_addr, dc_req_data, dc_req_be);
            end
            @(negedge clk);
        end
        do_drain();
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL single_drain_empty got %b exp 1", sb_empty); end
        checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %b exp 0", dc_req_valid); end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 4; i++) do_commit(26'h10 + 26'(i), 32'hA0 + 32'(i), 4'b1111);
        checks++; if (sb_full !== 1'b1) begin errors++; $display("FAIL full_set got %b exp 1", sb_full); end
        allow_overcommit = 1'b1;
        do_commit(26'h99, 32'h99, 4'b1111);
        allow_overcommit = 1'b0;
        checks++; if (sb_full !== 1'b1) begin errors++; $display("FAIL full_after_over got %b exp 1", sb_full); end
        checks++; if (dc_req_addr !== 26'h10) begin errors++; $display("FAIL over_head got %h exp 10", dc_req_addr); end
        ld_chk_valid = 1'b1;
        ld_chk_addr  = 26'h99;
        #1;
        checks++; if (ld_fwd_hit !== 1'b0) begin errors++; $display("FAIL over_not_stored got %b exp 0", ld_fwd_hit); end
        ld_chk_valid = 1'b0;
        do_drain();
        checks++; if (sb_full !== 1'b0) begin errors++; $display("FAIL full_clear got %b exp 0", sb_full); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (dc_req_addr !== 26'h10 + 26'(i)) begin errors++; $display("FAIL drain_order %0d got %h exp %h", i, dc_req_addr, 26'h10 + 26'(i)); end
            do_drain();
        end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL full_drained got %b exp 1", sb_empty); end
        for (int i = 0; i < 10; i++) begin
            do_commit(26'h400 + 26'(i), 32'h5000 + 32'(i), 4'b1111);
            checks++; if (dc_req_addr !== 26'h400 + 26'(i)) begin errors++; $display("FAIL wrap_order %0d got %h exp %h", i, dc_req_addr, 26'h400 + 26'(i)); end
            checks++; if (dc_req_data !== 32'h5000 + 32'(i)) begin errors++; $display("FAIL wrap_data %0d got %h exp %h", i, dc_req_data, 32'h5000 + 32'(i)); end
            do_drain();
        end
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", sb_empty); end
    endtask

    task automatic test_forward();
        do_commit(26'h200, 32'h11111111, 4'b1111);
        do_commit(26'h200, 32'h22222222, 4'b1111);
        ld_chk_valid = 1'b1;
        ld_chk_addr  = 26'h200;
        #1;
        checks++; if ({ld_fwd_hit, ld_fwd_stall} !== 2'b10) begin errors++; $display("FAIL fwd_hit got %b exp 10", {ld_fwd_hit, ld_fwd_stall}); end
        checks++; if (ld_fwd_data !== 32'h22222222) begin errors++; $display("FAIL fwd_youngest got %h exp 22222222", ld_fwd_data); end
        ld_chk_addr = 26'h204;
        #1;
        checks++; if ({ld_fwd_hit, ld_fwd_stall} !== 2'b00) begin errors++; $display("FAIL fwd_miss got %b exp 00", {ld_fwd_hit, ld_fwd_stall}); end
        ld_chk_addr  = 26'h200;
        ld_chk_valid = 1'b0;
        #1;
        checks++; if ({ld_fwd_hit, ld_fwd_stall, ld_fwd_data} !== 34'h0) begin errors++; $display("FAIL fwd_gated got %b/%b/%h exp 0", ld_fwd_hit, ld_fwd_stall, ld_fwd_data); end
        @(negedge clk);
        do_drain();
        ld_chk_valid = 1'b1;
        #1;
        checks++; if (ld_fwd_data !== 32'h22222222) begin errors++; $display("FAIL fwd_after_one_drain got %h exp 22222222", ld_fwd_data); end
        ld_chk_valid = 1'b0;
        @(negedge clk);
        do_drain();
    endtask

    task automatic test_partial();
        do_commit(26'h300, 32'h0000BEEF, 4'b0011);
        ld_chk_valid = 1'b1;
        ld_chk_addr  = 26'h300;
        #1;
        checks++; if ({ld_fwd_hit, ld_fwd_stall} !== 2'b01) begin errors++; $display("FAIL partial_stall got %b exp 01", {ld_fwd_hit, ld_fwd_stall}); end
        @(negedge clk);
        do_commit(26'h300, 32'hAAAA5555, 4'b1111);
        #1;
        checks++; if ({ld_fwd_hit, ld_fwd_stall, ld_fwd_data} !== {2'b10, 32'hAAAA5555}) begin errors++; $display("FAIL full_over_partial got %b%b/%h exp 10/aaaa5555", ld_fwd_hit, ld_fwd_stall, ld_fwd_data); end
        @(negedge clk);
        do_commit(26'h300, 32'h77000000, 4'b1000);
        #1;
        checks++; if ({ld_fwd_hit, ld_fwd_stall} !== 2'b01) begin errors++; $display("FAIL partial_over_full got %b exp 01", {ld_fwd_hit, ld_fwd_stall}); end
        @(negedge clk);
        repeat (3) do_drain();
        #1;
        checks++; if ({ld_fwd_hit, ld_fwd_stall} !== 2'b00) begin errors++; $display("FAIL partial_drained got %b exp 00", {ld_fwd_hit, ld_fwd_stall}); end
        ld_chk_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_commit(26'h500, 32'h500, 4'b1111);
        do_commit(26'h501, 32'h501, 4'b1111);
        commit_wr_en   = 1'b1;
        commit_wr_addr = 26'h502;
        commit_wr_data = 32'hCAFE0502;
        commit_wr_be   = 4'b1111;
        dc_req_ready   = 1'b1;
        ld_chk_valid   = 1'b1;
        ld_chk_addr    = 26'h502;
        #1;
        checks++; if (ld_fwd_hit !== 1'b0) begin errors++; $display("FAIL same_cycle_probe got %b exp 0", ld_fwd_hit); end
        ld_chk_addr = 26'h500;
        #1;
        checks++; if ({ld_fwd_hit, ld_fwd_data} !== {1'b1, 32'h500}) begin errors++; $display("FAIL head_in_handshake got %b/%h exp 1/500", ld_fwd_hit, ld_fwd_data); end
        ld_chk_addr = 26'h502;
        @(negedge clk);
        commit_wr_en = 1'b0;
        dc_req_ready = 1'b0;
        $display("commit 502 with drain of 500");
        #1;
        checks++; if ({ld_fwd_hit, ld_fwd_data} !== {1'b1, 32'hCAFE0502}) begin errors++; $display("FAIL next_cycle_probe got %b/%h exp 1/cafe0502", ld_fwd_hit, ld_fwd_data); end
        checks++; if ({sb_empty, sb_full, dc_req_addr} !== {2'b00, 26'h501}) begin errors++; $display("FAIL b2b_head got %b%b/%h exp 00/501", sb_empty, sb_full, dc_req_addr); end
        ld_chk_valid = 1'b0;
        @(negedge clk);
        do_drain();
        checks++; if ({sb_empty, dc_req_addr} !== {1'b0, 26'h502}) begin errors++; $display("FAIL b2b_occ2 got %b/%h exp 0/502", sb_empty, dc_req_addr); end
        do_drain();
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b exp 1", sb_empty); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) do_commit(26'h600 + 26'(i), 32'h600 + 32'(i), 4'b1111);
        dc_req_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        $display("async reset asserted mid-drain");
        checks++; if ({sb_empty, sb_full, dc_req_valid} !== 3'b100) begin errors++; $display("FAIL async_flags got %b exp 100", {sb_empty, sb_full, dc_req_valid}); end
        ld_chk_valid = 1'b1;
        ld_chk_addr  = 26'h600;
        #1;
        checks++; if ({ld_fwd_hit, ld_fwd_stall} !== 2'b00) begin errors++; $display("FAIL async_probe got %b exp 00", {ld_fwd_hit, ld_fwd_stall}); end
        ld_chk_valid = 1'b0;
        dc_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({sb_empty, dc_req_valid} !== 2'b10) begin errors++; $display("FAIL after_async got %b exp 10", {sb_empty, dc_req_valid}); end
    endtask

    initial begin
        rst            = 1'b1;
        commit_wr_en   = 1'b0;
        commit_wr_addr = '0;
        commit_wr_data = '0;
        commit_wr_be   = '0;
        dc_req_ready   = 1'b0;
        ld_chk_valid   = 1'b0;
        ld_chk_addr    = '0;
        test_reset();
        test_single();
        test_full_wrap();
        test_forward();
        test_partial();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
